// File: rtl/pwm_duty_meter_pkg.sv
// Shared constants and FSM encoding for the 0..100 PWM link (transmitter and receiver).
// The PWM_METER_FILTER_EN build option lives in pwm_in_sync.
package pwm_duty_meter_pkg;

   localparam int PWM_PERIOD   = 101;
   localparam int PWM_DUTY_MAX = 100;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_MEASURE = 1'b1
   } meter_state_t;

endpackage

// File: rtl/pwm_in_sync.sv
// Input conditioning for the PWM receiver: 2-flop synchronizer, history flops, rise detect.
// With PWM_METER_FILTER_EN defined a 3-sample majority filter sits in front of the edge detect.
module pwm_in_sync (
   input  logic clk,
   input  logic reset,
   input  logic pwm_in,
   output logic level,
   output logic rise
);

`ifdef PWM_METER_FILTER_EN
   localparam int DEPTH = 4;
`else
   localparam int DEPTH = 3;
`endif

   // sync_reg[0]=s1, [1]=s2, [2]=s3, [3]=s4 (filter build only)
   logic [DEPTH-1:0] sync_reg;

   always_ff @(posedge clk) begin
      if (reset) sync_reg[0] <= 1'b0;
      else       sync_reg[0] <= pwm_in;
   end

   genvar gi;
   generate
      for (gi = 1; gi < DEPTH; gi++) begin : g_chain
         always_ff @(posedge clk) begin
            if (reset) sync_reg[gi] <= 1'b0;
            else       sync_reg[gi] <= sync_reg[gi-1];
         end
      end
   endgenerate

`ifdef PWM_METER_FILTER_EN
   logic filt;
   logic filt_prev_reg;

   assign filt = (sync_reg[1] & sync_reg[2]) | (sync_reg[1] & sync_reg[3]) |
                 (sync_reg[2] & sync_reg[3]);

   always_ff @(posedge clk) begin
      if (reset) filt_prev_reg <= 1'b0;
      else       filt_prev_reg <= filt;
   end

   assign level = filt;
   assign rise  = filt & ~filt_prev_reg;
`else
   assign level = sync_reg[1];
   assign rise  = sync_reg[1] & ~sync_reg[2];
`endif

endmodule

// File: rtl/pwm_duty_meter.sv
// Receive side of the 0..100 PWM link: measures period and high time, reports duty per period.
// Build option PWM_METER_FILTER_EN enables the glitch filter inside pwm_in_sync.
module pwm_duty_meter
   import pwm_duty_meter_pkg::*;
#(
   parameter int N       = 7,
   parameter int CW      = 8,
   parameter int PERIOD  = PWM_PERIOD,
   parameter int TOL     = 0,
   parameter int TIMEOUT = 202
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         pwm_in,
   output logic [N-1:0] duty,
   output logic         duty_valid,
   output logic         period_err,
   output logic         locked
);

   logic          level;
   logic          rise;
   logic [CW-1:0] pc_reg;
   logic [CW-1:0] hc_reg;
   meter_state_t  state_reg;
   logic          timeout;
   logic          in_tol;
   int            pc_int;

   pwm_in_sync u_sync (
      .clk    (clk),
      .reset  (reset),
      .pwm_in (pwm_in),
      .level  (level),
      .rise   (rise)
   );

   assign pc_int  = int'(pc_reg);
   assign in_tol  = (pc_int >= PERIOD - TOL) && (pc_int <= PERIOD + TOL);
   assign timeout = (pc_reg == CW'(TIMEOUT));

   // pc/hc restart at 1 on a rise: the rising tick itself is the first tick of the new period.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_reg <= '0;
         hc_reg <= '0;
      end else if (rise) begin
         pc_reg <= CW'(1);
         hc_reg <= CW'(1);
      end else if (timeout) begin
         pc_reg <= CW'(1);
         hc_reg <= {{(CW-1){1'b0}}, level};
      end else begin
         pc_reg <= pc_reg + CW'(1);
         hc_reg <= hc_reg + {{(CW-1){1'b0}}, level};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= ST_IDLE;
         duty       <= '0;
         duty_valid <= 1'b0;
         period_err <= 1'b0;
         locked     <= 1'b0;
      end else begin
         duty_valid <= 1'b0;
         period_err <= 1'b0;
         if (rise) begin
            if (state_reg == ST_IDLE) begin
               state_reg <= ST_MEASURE;
            end else if (in_tol) begin
               duty       <= (hc_reg > CW'(PWM_DUTY_MAX)) ? N'(PWM_DUTY_MAX) : hc_reg[N-1:0];
               duty_valid <= 1'b1;
               locked     <= 1'b1;
            end else begin
               period_err <= 1'b1;
               locked     <= 1'b0;
            end
         end else if (timeout) begin
            // Constant level: report 0 or 100 without touching the FSM state.
            duty       <= level ? N'(PWM_DUTY_MAX) : '0;
            duty_valid <= 1'b1;
            locked     <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Self-checking bench for pwm_duty_meter (default build, PWM_METER_FILTER_EN undefined).
// Reference: per-period arithmetic over the recorded input history, checked every cycle.
module tb_pwm_duty_meter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       pwm_in = 1'b0;
   logic [6:0] duty;
   logic       duty_valid;
   logic       period_err;
   logic       locked;

   int tests = 0;
   int fails = 0;

   pwm_duty_meter dut (
      .clk        (clk),
      .reset      (reset),
      .pwm_in     (pwm_in),
      .duty       (duty),
      .duty_valid (duty_valid),
      .period_err (period_err),
      .locked     (locked)
   );

   always #5 clk = ~clk;

   // Input history indexed by clock edge; model state
   bit lv [0:16383];
   int cyc = 4;
   int anchor = 0;
   bit m_idle = 1'b1;
   int e_duty = 0;
   int e_dv = 0;
   int e_pe = 0;
   int e_locked = 0;

   task automatic check(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s at edge %0d: got %0d, expected %0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      lv[cyc]   = 1'b0;
      lv[cyc-1] = 1'b0;
      anchor    = cyc - 1;
      m_idle    = 1'b1;
      e_duty    = 0;
      e_dv      = 0;
      e_pe      = 0;
      e_locked  = 0;
   endtask

   // Level j is seen by the meter two edges after it was driven; its result shows after edge j+2.
   task automatic model_process(input int j);
      int pcm;
      int hcm;
      bit r;
      r    = lv[j] && !lv[j-1];
      pcm  = j - anchor;
      hcm  = 0;
      for (int k = anchor; k < j; k++) hcm += int'(lv[k]);
      e_dv = 0;
      e_pe = 0;
      if (r) begin
         anchor = j;
         if (m_idle) begin
            m_idle = 1'b0;
         end else if (pcm == 101) begin
            e_duty   = (hcm > 100) ? 100 : hcm;
            e_dv     = 1;
            e_locked = 1;
         end else begin
            e_pe     = 1;
            e_locked = 0;
         end
      end else if (pcm == 202) begin
         anchor   = j;
         e_duty   = lv[j] ? 100 : 0;
         e_dv     = 1;
         e_locked = 0;
      end
   endtask

   task automatic step(input logic v);
      pwm_in = v;
      @(posedge clk);
      cyc++;
      if (cyc > 16383) begin
         $display("FAIL cycle_budget exceeded at edge %0d", cyc);
         $fatal(1, "cycle budget");
      end
      lv[cyc] = v;
      if (reset) model_reset();
      else       model_process(cyc - 2);
      #1;
      check("duty",       int'(duty),       e_duty);
      check("duty_valid", int'(duty_valid), e_dv);
      check("period_err", int'(period_err), e_pe);
      check("locked",     int'(locked),     e_locked);
   endtask

   task automatic pwm_period(input int d, input int p);
      for (int i = 0; i < p; i++) step(i < d);
   endtask

   initial begin
      int d;
      int p;
      int dv_seen;

      // Reset state
      reset = 1'b1;
      step(1'b0);
      step(1'b0);
      check("rst_duty", int'(duty), 0);
      check("rst_valid", int'(duty_valid), 0);
      check("rst_locked", int'(locked), 0);
      reset = 1'b0;
      step(1'b0);

      // Steady duty 40 at the nominal period
      for (int n = 0; n < 4; n++) pwm_period(40, 101);
      step(1'b1);
      check("duty40_locked", int'(locked), 1);

      // Extreme and random duties at the nominal period
      for (int n = 0; n < 2; n++) pwm_period(1, 101);
      for (int n = 0; n < 2; n++) pwm_period(99, 101);
      for (int n = 0; n < 6; n++) pwm_period($urandom_range(1, 99), 101);

      // Constant low, then constant high: timeout reports
      for (int i = 0; i < 500; i++) step(1'b0);
      for (int i = 0; i < 500; i++) step(1'b1);
      check("high_unlocked", int'(locked), 0);

      // Off-nominal period 90: period_err per rise, duty holds
      pwm_period(1, 101);
      for (int n = 0; n < 2; n++) pwm_period(60, 101);
      for (int n = 0; n < 4; n++) pwm_period(45, 90);

      // 1-cycle glitch in the low phase is a genuine rise without the filter
      for (int n = 0; n < 2; n++) pwm_period(30, 101);
      for (int i = 0; i < 101; i++) step((i < 30) || (i == 60));
      for (int n = 0; n < 2; n++) pwm_period(30, 101);

      // Reset at tick 50 of a period
      for (int i = 0; i < 50; i++) step(i < 40);
      reset = 1'b1;
      step(1'b0);
      check("midrst_duty", int'(duty), 0);
      check("midrst_locked", int'(locked), 0);
      reset = 1'b0;
      for (int i = 51; i < 101; i++) step(1'b0);
      dv_seen = 0;
      for (int i = 0; i < 101; i++) begin
         step(i < 40);
         dv_seen += int'(duty_valid);
      end
      check("midrst_first_rise_nostrobe", dv_seen, 0);
      for (int n = 0; n < 2; n++) pwm_period(70, 101);

      // Random periods around nominal with random duty
      for (int n = 0; n < 10; n++) begin
         p = $urandom_range(95, 107);
         d = $urandom_range(1, p - 1);
         pwm_period(d, p);
      end
      for (int i = 0; i < 20; i++) step(1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
